// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the iterative AES key schedule.
//   keylen_t : run-time key length selector (reserved encoding behaves as 128-bit)
//   nk_of()  : key length in 32-bit words, capped by the key port width
//   nr_of()  : number of rounds (Nk + 6)
//   xtime()  : GF(2^8) multiply-by-x, used to step the round constant
package aes_key_pkg;

    localparam int RK_W       = 128;
    localparam int MAX_ROUNDS = 14;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_RSV = 2'b11
    } keylen_t;

    // A length wider than the key port cannot be honoured, so it falls back to 128
    function automatic logic [3:0] nk_of(input keylen_t kl, input int max_bits);
        logic [3:0] nk;
        case (kl)
            KL_192:  nk = (max_bits >= 192) ? 4'd6 : 4'd4;
            KL_256:  nk = (max_bits >= 256) ? 4'd8 : 4'd4;
            default: nk = 4'd4;
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input keylen_t kl, input int max_bits);
        return nk_of(kl, max_bits) + 4'd6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_sched_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word_i : input word
//   word_o : byte-wise S-box substituted word
// The S-box is computed as the GF(2^8) inverse (x^254) followed by the
// AES affine transform, which keeps the source free of a 256-entry table.
module aes_key_sched_subword
    import aes_key_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Four independent byte substitutions
    always_comb begin
        word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                  sbox(word_i[15:8]),  sbox(word_i[7:0])};
    end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key schedule (128/192/256-bit keys, chosen per run).
// One expanded word w[i] is produced per cycle; every fourth word completes
// a round key which is offered on a valid/ready stream in order 0..Nr.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start_i         : begin a schedule (sampled only when idle)
//   key_len_i       : 00=128, 01=192, 10=256, 11=128
//   key_i           : cipher key, MSB-aligned (w[0] = key_i[MSB -: 32])
//   rev_start_i     : (AES_KEY_STORE_EN only) replay stored round keys Nr..0
//   busy_o          : schedule or replay in progress
//   rk_valid_o/rk_ready_i/rk_data_o/rk_idx_o/rk_last_o : round key stream
//   done_o          : one-cycle pulse after the final beat is accepted
// Optional feature macro: AES_KEY_STORE_EN (round key store + reverse replay).
module aes_key_sched
    import aes_key_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [1:0]              key_len_i,
    input  logic [MAX_KEY_BITS-1:0] key_i,
`ifdef AES_KEY_STORE_EN
    input  logic                    rev_start_i,
`endif
    output logic                    busy_o,
    output logic                    rk_valid_o,
    input  logic                    rk_ready_i,
    output logic [RK_W-1:0]         rk_data_o,
    output logic [3:0]              rk_idx_o,
    output logic                    rk_last_o,
    output logic                    done_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GEN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
`ifdef AES_KEY_STORE_EN
    localparam logic [1:0] ST_REV   = 2'd3;
`endif

    logic [1:0]              state_q, state_d;
    logic [MAX_KEY_BITS-1:0] key_q;
    logic [31:0]             win_q [8];   // win_q[0] = w[i-1], win_q[j] = w[i-1-j]
    logic [95:0]             asm_q;
    logic [5:0]              word_q;
    logic [2:0]              mod_q;       // i % Nk, tracked incrementally
    logic [7:0]              rcon_q;
    logic [3:0]              nk_q;
    logic [3:0]              nr_q;
    logic                    busy_q;
    logic                    valid_q;
    logic [RK_W-1:0]         data_q;
    logic [3:0]              idx_q;
    logic                    last_q;
    logic                    done_q;
`ifdef AES_KEY_STORE_EN
    logic [RK_W-1:0]         store_q [MAX_ROUNDS+1];
    logic                    stored_q;
`endif

    logic        accept_s, gen_en_s, last_word_s, is_key_s;
    logic [5:0]  total_words_s;
    logic [31:0] prev_s, far_s, sub_in_s, sub_out_s, word_s;

    aes_key_sched_subword u_subword (
        .word_i (sub_in_s),
        .word_o (sub_out_s)
    );

    // Word generator datapath: the single SubWord serves both the Rot+Sub and the Nk=8 Sub case
    always_comb begin
        accept_s      = valid_q && rk_ready_i;
        gen_en_s      = (state_q == ST_GEN) && (!valid_q || rk_ready_i);
        total_words_s = {nr_q, 2'b00} + 6'd4;
        last_word_s   = (word_q == (total_words_s - 6'd1));
        is_key_s      = (word_q < {2'b00, nk_q});
        prev_s        = win_q[0];
        far_s         = win_q[nk_q[2:0] - 3'd1];
        sub_in_s      = (mod_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        if (is_key_s) begin
            word_s = key_q[MAX_KEY_BITS-1 -: 32];
        end else if (mod_q == 3'd0) begin
            word_s = far_s ^ sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
            word_s = far_s ^ sub_out_s;
        end else begin
            word_s = far_s ^ prev_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_GEN;
`ifdef AES_KEY_STORE_EN
                end else if (rev_start_i && stored_q) begin
                    state_d = ST_REV;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (gen_en_s && last_word_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_GEN;
                end
            end
            ST_DRAIN: begin
                if (accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
`ifdef AES_KEY_STORE_EN
            ST_REV: begin
                if (accept_s && last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REV;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State, window, assembly and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            for (int j = 0; j < 8; j++) begin
                win_q[j] <= 32'h0;
            end
            asm_q   <= 96'h0;
            word_q  <= 6'd0;
            mod_q   <= 3'd0;
            rcon_q  <= 8'h01;
            nk_q    <= 4'd4;
            nr_q    <= 4'd10;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= 4'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_KEY_STORE_EN
            stored_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q  <= key_i;
                        nk_q   <= nk_of(keylen_t'(key_len_i), MAX_KEY_BITS);
                        nr_q   <= nr_of(keylen_t'(key_len_i), MAX_KEY_BITS);
                        word_q <= 6'd0;
                        mod_q  <= 3'd0;
                        rcon_q <= 8'h01;
                        busy_q <= 1'b1;
`ifdef AES_KEY_STORE_EN
                    end else if (rev_start_i && stored_q) begin
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        data_q  <= store_q[nr_q];
                        idx_q   <= nr_q;
                        last_q  <= 1'b0;
`endif
                    end
                end
                ST_GEN: begin
                    if (gen_en_s) begin
                        key_q    <= {key_q[MAX_KEY_BITS-33:0], 32'h0};
                        win_q[0] <= word_s;
                        for (int j = 1; j < 8; j++) begin
                            win_q[j] <= win_q[j-1];
                        end
                        asm_q  <= {asm_q[63:0], word_s};
                        word_q <= word_q + 6'd1;
                        mod_q  <= (mod_q == (nk_q[2:0] - 3'd1)) ? 3'd0 : (mod_q + 3'd1);
                        if (!is_key_s && (mod_q == 3'd0)) begin
                            rcon_q <= xtime(rcon_q);
                        end
                        // Fourth word of a round: hand the whole round key to the output
                        if (word_q[1:0] == 2'b11) begin
                            valid_q <= 1'b1;
                            data_q  <= {asm_q, word_s};
                            idx_q   <= word_q[5:2];
                            last_q  <= (word_q[5:2] == nr_q);
`ifdef AES_KEY_STORE_EN
                            store_q[word_q[5:2]] <= {asm_q, word_s};
`endif
                        end else if (accept_s) begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_s) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef AES_KEY_STORE_EN
                        stored_q <= 1'b1;
`endif
                    end
                end
`ifdef AES_KEY_STORE_EN
                ST_REV: begin
                    if (accept_s) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            data_q <= store_q[idx_q - 4'd1];
                            idx_q  <= idx_q - 4'd1;
                            last_q <= (idx_q == 4'd1);
                        end
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign rk_valid_o = valid_q;
    assign rk_data_o  = data_q;
    assign rk_idx_o   = idx_q;
    assign rk_last_o  = last_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: known-answer vectors, random keys,
// random backpressure, ignored restarts, mid-schedule reset and (with
// AES_KEY_STORE_EN) reverse replay, against a word-level reference model.
module tb_aes_key_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [1:0]   key_len_i;
    logic [255:0] key_i;
    logic         busy_o, rk_valid_o, rk_ready_i, rk_last_o, done_o;
    logic [127:0] rk_data_o;
    logic [3:0]   rk_idx_o;
`ifdef AES_KEY_STORE_EN
    logic         rev_start_i;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_rk [15];
    int           exp_nr;

    always #5 clk = ~clk;

    aes_key_sched #(.MAX_KEY_BITS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .key_len_i  (key_len_i),
        .key_i      (key_i),
`ifdef AES_KEY_STORE_EN
        .rev_start_i(rev_start_i),
`endif
        .busy_o     (busy_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .rk_data_o  (rk_data_o),
        .rk_idx_o   (rk_idx_o),
        .rk_last_o  (rk_last_o),
        .done_o     (done_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rotl8(input int v, input int s);
        return ((v << s) | (v >> (8 - s))) & 255;
    endfunction

    // S-box from the generator walk: p steps by x3, q by its inverse
    function automatic void build_sbox();
        int p = 1;
        int q = 1;
        int x;
        do begin
            p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            q = q & 255;
            if ((q & 128) != 0) q = q ^ 9;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox_t[p] = 8'((x ^ 99) & 255);
        end while (p != 1);
        sbox_t[0] = 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Reference expansion straight from the FIPS-197 word recurrence
    function automatic void model(input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        int nk;
        int rc;
        nk = (kl == 2'b01) ? 6 : ((kl == 2'b10) ? 8 : 4);
        exp_nr = nk + 6;
        rc = 1;
        for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
                    rc = (rc << 1) ^ ((rc >= 128) ? 283 : 0);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        for (int r = 0; r <= exp_nr; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  busy_o,     1'b0);
        check({tag, "_valid"}, rk_valid_o, 1'b0);
        check({tag, "_data"},  rk_data_o,  128'h0);
        check({tag, "_idx"},   rk_idx_o,   4'd0);
        check({tag, "_last"},  rk_last_o,  1'b0);
        check({tag, "_done"},  done_o,     1'b0);
    endtask

    // Runs one forward schedule; abort_at>0 returns after that many beats accepted
    task automatic run_fwd(input logic [1:0] kl, input logic [255:0] key, input int pct,
                           input int abort_at, input string tag);
        int cnt = 0;
        int cyc = 0;
        int first_valid = -1;
        bit fin = 1'b0;
        bit stall = 1'b0;
        logic [127:0] pd;
        logic [3:0] pi;
        logic pl;
        model(kl, key);
        @(negedge clk);
        key_len_i = kl;
        key_i = key;
        start_i = 1'b1;
        @(negedge clk);
        check({tag, "_busy_after_start"}, busy_o, 1'b1);
        key_i = rand256();
        key_len_i = 2'($urandom_range(0, 3));
        start_i = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                check({tag, "_stall_valid"}, rk_valid_o, 1'b1);
                check({tag, "_stall_data"}, rk_data_o, pd);
                check({tag, "_stall_idx"}, rk_idx_o, pi);
                check({tag, "_stall_last"}, rk_last_o, pl);
            end
            rk_ready_i = ($urandom_range(0, 99) < pct);
            start_i = 1'($urandom_range(0, 1));
            if (rk_valid_o && first_valid < 0) first_valid = cyc;
            if (rk_valid_o && rk_ready_i) begin
                got_rk[cnt] = rk_data_o;
                check({tag, "_idx"}, rk_idx_o, 128'(cnt));
                check({tag, "_data"}, rk_data_o, exp_rk[cnt]);
                check({tag, "_last"}, rk_last_o, (cnt == exp_nr));
                if (cnt == exp_nr) begin
                    fin = 1'b1;
                    start_i = 1'b0;
                    if (pct >= 100) begin
                        check({tag, "_first_beat_cycle"}, 128'(first_valid), 128'd4);
                        check({tag, "_last_beat_cycle"}, 128'(cyc), 128'(4 * (exp_nr + 1)));
                    end
                end
                cnt++;
                if (cnt == abort_at) begin
                    start_i = 1'b0;
                    return;
                end
            end
            stall = rk_valid_o && !rk_ready_i;
            pd = rk_data_o;
            pi = rk_idx_o;
            pl = rk_last_o;
        end
        start_i = 1'b0;
        check({tag, "_completed"}, fin, 1'b1);
        check({tag, "_beat_count"}, 128'(cnt), 128'(exp_nr + 1));
        @(negedge clk);
        check({tag, "_done_pulse"}, done_o, 1'b1);
        check({tag, "_busy_end"}, busy_o, 1'b0);
        check({tag, "_valid_end"}, rk_valid_o, 1'b0);
        @(negedge clk);
        check({tag, "_done_once"}, done_o, 1'b0);
    endtask

`ifdef AES_KEY_STORE_EN
    task automatic run_rev(input string tag);
        int cnt = exp_nr;
        int cyc = 0;
        bit fin = 1'b0;
        @(negedge clk);
        rk_ready_i = 1'b1;
        rev_start_i = 1'b1;
        @(negedge clk);
        rev_start_i = 1'b0;
        while (!fin && cyc < 100) begin
            if (rk_valid_o) begin
                check({tag, "_idx"}, rk_idx_o, 128'(cnt));
                check({tag, "_data"}, rk_data_o, exp_rk[cnt]);
                check({tag, "_last"}, rk_last_o, (cnt == 0));
                if (cnt == 0) fin = 1'b1;
                cnt--;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_completed"}, fin, 1'b1);
        check({tag, "_done_pulse"}, done_o, 1'b1);
    endtask
`endif

    initial begin
        build_sbox();
        reset = 1'b1;
        start_i = 1'b0;
        rk_ready_i = 1'b0;
        key_len_i = 2'b00;
        key_i = 256'h0;
`ifdef AES_KEY_STORE_EN
        rev_start_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        run_fwd(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 100, -1, "aes128");
        check("kat128_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("kat128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef AES_KEY_STORE_EN
        run_rev("rev128");
`endif

        run_fwd(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                100, -1, "aes192");
        check("kat192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run_fwd(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                100, -1, "aes256");
        check("kat256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_fwd(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                30, -1, "aes256_bp");
        check("bp256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        run_fwd(2'b11, rand256(), 50, -1, "reserved_len");
        for (int k = 0; k < 3; k++) begin
            run_fwd(2'(k), rand256(), 60, -1, "random_key");
        end

        run_fwd(2'b00, rand256(), 100, 5, "pre_reset");
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        reset = 1'b0;
        run_fwd(2'b01, rand256(), 70, -1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
